velox_pulse_checker: RTL

// In-fabric receiver/monitor for the velox blink output: samples the LED line,

---
 rtl/velox_pulse_checker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/velox_pulse_checker.sv
// Receiver/monitor for the velox blink output. Measures clocks between LED
// toggles and checks each interval against one second, +/- tol cycles.
module velox_pulse_checker #(
   parameter int unsigned clk_freq_hz = 50_000,
   parameter int unsigned pulses      = 5,
   parameter int unsigned tol         = 0,
   parameter int unsigned cnt_w       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             q,
   output logic             pulse_ok,
   output logic             err,
   output logic [1:0]       err_code,
   output logic             done,
   output logic [15:0]      good_cnt,
   output logic [cnt_w-1:0] last_period
);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEASURE, S_DONE, S_ERROR} state_t;
   typedef enum logic [1:0] {E_NONE, E_SHORT, E_LONG, E_TIMEOUT} err_t;

   localparam logic [cnt_w-1:0] lim_lo  = cnt_w'(clk_freq_hz - tol);
   localparam logic [cnt_w-1:0] lim_hi  = cnt_w'(clk_freq_hz + tol);
   localparam logic [cnt_w-1:0] cnt_max = '1;
   localparam logic [15:0]      good_max = 16'hffff;
   localparam logic [15:0]      pulses_c = 16'(pulses);

   state_t           state, state_d;
   err_t             err_q, err_d;
   logic             pulse_ok_d;
   logic [15:0]      good_cnt_d, good_inc;
   logic [cnt_w-1:0] last_period_d;
   logic [cnt_w-1:0] cnt, period;
   logic             sync1, sync2, sync3, edge_det;

   // Two flops for metastability, a third to remember the previous level;
   // every edge takes the same path, so measured intervals carry no skew.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // the pre-edge value of its neighbours, exactly like the hardware.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= q;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign edge_det = sync2 ^ sync3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               cnt <= '0;
      else if (edge_det)        cnt <= '0;
      else if (cnt != cnt_max)  cnt <= cnt + cnt_w'(1);
   end

   // Interval ending at this cycle; cnt restarts at 0 on the cycle after an edge.
   assign period   = (cnt == cnt_max) ? cnt : cnt + cnt_w'(1);
   assign good_inc = (good_cnt == good_max) ? good_cnt : good_cnt + 16'd1;

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave a value unassigned and infer a latch.
   always_comb begin
      state_d       = state;
      err_d         = err_q;
      pulse_ok_d    = 1'b0;
      good_cnt_d    = good_cnt;
      last_period_d = last_period;
      if (!en) begin
         state_d    = S_IDLE;
         good_cnt_d = '0;
         err_d      = E_NONE;
      end else begin
         unique case (state)
            S_IDLE: begin
               good_cnt_d = '0;
               err_d      = E_NONE;
               state_d    = S_ARM;
            end
            S_ARM: begin
               if (edge_det) state_d = S_MEASURE;
            end
            S_MEASURE: begin
               if (edge_det) begin
                  last_period_d = period;
                  if (period >= lim_lo && period <= lim_hi) begin
                     pulse_ok_d = 1'b1;
                     good_cnt_d = good_inc;
                     if (good_inc == pulses_c) state_d = S_DONE;
                  end else if (period < lim_lo) begin
                     err_d   = E_SHORT;
                     state_d = S_ERROR;
                  end else begin
                     err_d   = E_LONG;
                     state_d = S_ERROR;
                  end
               end else if (period > lim_hi) begin
                  // Report a missing edge as soon as it is overdue.
                  err_d   = E_TIMEOUT;
                  state_d = S_ERROR;
               end
            end
            S_DONE, S_ERROR: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         err_q       <= E_NONE;
         pulse_ok    <= 1'b0;
         good_cnt    <= '0;
         last_period <= '0;
      end else begin
         state       <= state_d;
         err_q       <= err_d;
         pulse_ok    <= pulse_ok_d;
         good_cnt    <= good_cnt_d;
         last_period <= last_period_d;
      end
   end

   assign err      = (state == S_ERROR);
   assign done     = (state == S_DONE);
   assign err_code = err_q;

endmodule
